// File: rtl/apb_pkg.sv
// Shared APB types, widths and PPROT helpers used by both the bridge and the completer.
package apb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ABORT
  } apb_state_e;

  localparam int PPROT_PRIV_BIT  = 0;
  localparam int PPROT_NSEC_BIT  = 1;
  localparam int PPROT_INSTR_BIT = 2;

  // Address bits [6:4] encode the PPROT attributes a region demands.
  function automatic logic [2:0] getPprot(input logic [ADDR_WIDTH-1:0] addr);
    return addr[6:4];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] getAddrforPprot(input logic [2:0] pprot,
                                                            input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] r;
    r      = addr;
    r[6:4] = pprot;
    return r;
  endfunction

  function automatic logic pprot_ok(input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] pprot);
    return (getPprot(addr) & ~pprot) == 3'b000;
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB4 bus shared by apb_bridge (requester) and apb_completer.
interface apb_if
  import apb_pkg::*;
(
  input logic pclk,
  input logic presetn
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport requester (
    input  pclk, presetn, prdata, pready, pslverr,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

  modport completer (
    input  pclk, presetn, psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_completer_mem.sv
// DEPTH x 32 register memory: byte-enabled write port, combinational read port, async clear.
module apb_completer_mem
  import apb_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [STRB_WIDTH-1:0] be,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is reset because clear-on-reset is part of the register map's
  // contract; this deliberately keeps it in flops rather than an inferred RAM.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_completer.sv
// APB4 completer: FSM, alignment/range/PPROT checks and registered responses.
// Optional APB_WAIT_STATES_EN inserts WAIT_STATES access-phase wait cycles.
module apb_completer
  import apb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  apb_if.completer apb
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH * 4);

  if (DEPTH < 32) begin : g_depth_chk
    $error("apb_completer: DEPTH must be at least 32");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
    $error("apb_completer: WAIT_STATES must be 0..15");
  end

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wait_done;
  logic                  setup_req, access_req, violation, new_err, mem_we;
  logic [IDX_W-1:0]      idx;

`ifdef APB_WAIT_STATES_EN
  logic [3:0] wait_cnt_q;

  always_ff @(posedge apb.pclk or negedge apb.presetn) begin
    if (!apb.presetn) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP && state_d == ACCESS) begin
      wait_cnt_q <= 4'(WAIT_STATES);
    end else if (state_q == ACCESS && wait_cnt_q != '0) begin
      wait_cnt_q <= wait_cnt_q - 4'd1;
    end
  end

  assign wait_done = (wait_cnt_q == '0);
`else
  assign wait_done = 1'b1;
`endif

  assign setup_req  = apb.psel & ~apb.penable;
  assign access_req = apb.psel &  apb.penable;
  // Once in ACCESS the requester must hold the transfer stable until pready.
  assign violation  = ~apb.psel | (apb.paddr != addr_q) | (apb.pwrite != write_q);
  assign new_err    = (apb.paddr[1:0] != 2'b00) | (apb.paddr >= ADDR_LIMIT)
                    | ~pprot_ok(apb.paddr, apb.pprot);

  // NOTE: next-state defaults to the current state first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup_req) state_d = SETUP;
      SETUP:   state_d = access_req ? ACCESS : ABORT;
      ACCESS:  begin
        if (wait_done)      state_d = IDLE;
        else if (violation) state_d = ABORT;
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge apb.pclk or negedge apb.presetn) begin
    if (!apb.presetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && setup_req) begin
        addr_q  <= apb.paddr;
        write_q <= apb.pwrite;
        wdata_q <= apb.pwdata;
        strb_q  <= apb.pstrb;
        err_q   <= new_err;
      end
      // prdata is non-zero only while in ACCESS for a clean read.
      if (state_q == SETUP && state_d == ACCESS) begin
        prdata_q <= (!write_q && !err_q) ? mem_rdata : '0;
      end else if (state_d != ACCESS) begin
        prdata_q <= '0;
      end
    end
  end

  assign idx    = addr_q[IDX_W+1:2];
  assign mem_we = (state_q == ACCESS) && wait_done && write_q && !err_q;

  apb_completer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (apb.pclk),
    .rst_n (apb.presetn),
    .we    (mem_we),
    .be    (strb_q),
    .waddr (idx),
    .wdata (wdata_q),
    .raddr (idx),
    .rdata (mem_rdata)
  );

  assign apb.pready  = ((state_q == ACCESS) && wait_done) || (state_q == ABORT);
  assign apb.pslverr = apb.pready && (err_q || (state_q == ABORT));
  assign apb.prdata  = prdata_q;

endmodule
